// File: rtl/gameover_ctrl.sv
// Life / game-over controller: counts lives from collision edges, applies
// post-hit invulnerability, latches game over and gates restart. Optional extra-life input under GAMEOVER_EXTRA_LIFE_EN.
module gameover_ctrl #(
  parameter int START_LIVES      = 3,
  parameter int LIFE_W           = 3,
  parameter int INVULN_FRAMES    = 60,
  parameter int OVER_HOLD_FRAMES = 120
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              collision,
  input  logic              tick,
`ifdef GAMEOVER_EXTRA_LIFE_EN
  input  logic              extra_life,
`endif
  output logic [LIFE_W-1:0] lives,
  output logic              playing,
  output logic              invuln,
  output logic              gameover
);

  localparam int CNT_MAX = (INVULN_FRAMES > OVER_HOLD_FRAMES) ? INVULN_FRAMES : OVER_HOLD_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  INV_LOAD  = CNT_W'(INVULN_FRAMES);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(OVER_HOLD_FRAMES);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [LIFE_W-1:0] LIVES_START = LIFE_W'(START_LIVES);
  localparam logic [LIFE_W-1:0] LIVES_MAX   = {LIFE_W{1'b1}};
  localparam logic [LIFE_W-1:0] LIVES_ONE   = LIFE_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    INVULN,
    OVER
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              collision_q;
  logic              hit;
  logic              bonus;
  logic [LIFE_W-1:0] lives_up;

  // Only the rising edge of collision counts, so a held overlap costs one life.
  assign hit = collision & ~collision_q;

`ifdef GAMEOVER_EXTRA_LIFE_EN
  assign bonus = extra_life;
`else
  assign bonus = 1'b0;
`endif

  assign lives_up = (lives == LIVES_MAX) ? lives : lives + LIVES_ONE;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      collision_q <= 1'b0;
      lives       <= '0;
      playing     <= 1'b0;
      invuln      <= 1'b0;
      gameover    <= 1'b0;
    end else begin
      collision_q <= collision;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= PLAY;
            lives   <= LIVES_START;
            playing <= 1'b1;
          end
        end

        PLAY: begin
          if (hit && bonus) begin
            // Extra life cancels the hit's cost but the shield still applies.
            state  <= INVULN;
            cnt    <= INV_LOAD;
            invuln <= 1'b1;
          end else if (hit && (lives > LIVES_ONE)) begin
            state  <= INVULN;
            lives  <= lives - LIVES_ONE;
            cnt    <= INV_LOAD;
            invuln <= 1'b1;
          end else if (hit) begin
            state    <= OVER;
            lives    <= '0;
            cnt      <= HOLD_LOAD;
            playing  <= 1'b0;
            gameover <= 1'b1;
          end else if (bonus) begin
            lives <= lives_up;
          end
        end

        INVULN: begin
          if (bonus) begin
            lives <= lives_up;
          end
          if (tick) begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              state  <= PLAY;
              invuln <= 1'b0;
            end
          end
        end

        OVER: begin
          // Restart only once the hold has fully elapsed; early presses are dropped.
          if (start && (cnt == '0)) begin
            state    <= PLAY;
            lives    <= LIVES_START;
            playing  <= 1'b1;
            gameover <= 1'b0;
          end else if (tick && (cnt != '0)) begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gameover_ctrl.sv
// Bench for gameover_ctrl: directed scenarios followed by random play, all
// compared cycle by cycle against a rule-level model of lives, shield and hold timer.
module tb_gameover_ctrl;

  localparam int START = 3;
  localparam int LW    = 3;
  localparam int INV   = 60;
  localparam int HOLD  = 120;
  localparam int LMAX  = (1 << LW) - 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          collision = 1'b0;
  logic          tick = 1'b0;
  logic          el = 1'b0;
  logic [LW-1:0] lives;
  logic          playing;
  logic          invuln;
  logic          gameover;

  int total  = 0;
  int passes = 0;

  // Reference model: game facts rather than controller states.
  bit m_active;   // a game is in progress and the player is alive
  bit m_shield;   // player currently cannot be hurt
  bit m_over;     // game lost, waiting for restart
  int m_lives;
  int m_timer;    // frames left on the shield or the game-over hold
  bit m_prev;     // collision level seen last cycle

  gameover_ctrl #(
    .START_LIVES(START),
    .LIFE_W(LW),
    .INVULN_FRAMES(INV),
    .OVER_HOLD_FRAMES(HOLD)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .collision(collision),
    .tick(tick),
`ifdef GAMEOVER_EXTRA_LIFE_EN
    .extra_life(el),
`endif
    .lives(lives),
    .playing(playing),
    .invuln(invuln),
    .gameover(gameover)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_active = 0; m_shield = 0; m_over = 0;
    m_lives = 0; m_timer = 0; m_prev = 0;
  endtask

  task automatic model_step(input bit s, input bit c, input bit t, input bit e);
    bit hit;
    bit bonus;
    hit    = c && !m_prev;
    m_prev = c;
`ifdef GAMEOVER_EXTRA_LIFE_EN
    bonus = e;
`else
    bonus = 1'b0;
`endif
    if (m_over) begin
      if (s && m_timer == 0) begin
        m_over = 0; m_active = 1; m_lives = START;
      end else if (t && m_timer > 0) begin
        m_timer--;
      end
    end else if (m_active && !m_shield) begin
      if (hit && bonus) begin
        m_shield = 1; m_timer = INV;
      end else if (hit && m_lives > 1) begin
        m_lives--; m_shield = 1; m_timer = INV;
      end else if (hit) begin
        m_lives = 0; m_active = 0; m_over = 1; m_timer = HOLD;
      end else if (bonus) begin
        m_lives = (m_lives < LMAX) ? m_lives + 1 : LMAX;
      end
    end else if (m_active) begin
      if (bonus) m_lives = (m_lives < LMAX) ? m_lives + 1 : LMAX;
      if (t) begin
        m_timer--;
        if (m_timer == 0) m_shield = 0;
      end
    end else if (s) begin
      m_active = 1; m_lives = START;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".lives"},    32'(lives),    32'(m_lives));
    chk({tag, ".playing"},  32'(playing),  32'(m_active));
    chk({tag, ".invuln"},   32'(invuln),   32'(m_shield));
    chk({tag, ".gameover"}, 32'(gameover), 32'(m_over));
  endtask

  // One clock: inputs applied just after the previous edge, outputs checked 1 ns after this one.
  task automatic cyc(input bit s, input bit c, input bit t, input string tag);
    start = s; collision = c; tick = t;
    @(posedge clk);
    #1;
    model_step(s, c, t, el);
    chk_model(tag);
    start = 0; tick = 0; el = 0;
  endtask

  task automatic ticks(input int n, input bit c, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, c, 1'b1, tag);
  endtask

  task automatic async_reset(input string tag);
    #3;
    resetn = 1'b0;
    #1;
    model_reset();
    chk({tag, ".lives"},    32'(lives),    0);
    chk({tag, ".playing"},  32'(playing),  0);
    chk({tag, ".invuln"},   32'(invuln),   0);
    chk({tag, ".gameover"}, 32'(gameover), 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.lives", 32'(lives), 0);
    chk("reset.playing", 32'(playing), 0);
    chk("reset.gameover", 32'(gameover), 0);
    resetn = 1'b1;
    cyc(0, 0, 1, "idle_tick");
    cyc(0, 1, 0, "idle_hit");
    cyc(0, 0, 0, "idle_quiet");

    cyc(1, 0, 0, "start");
    chk("start.lives", 32'(lives), 3);
    cyc(1, 0, 0, "play_start_ignored");

    // Hit and tick in the same cycle: hit wins, full shield loaded.
    cyc(0, 1, 1, "hit_tick");
    chk("hit_tick.lives", 32'(lives), 2);
    chk("hit_tick.invuln", 32'(invuln), 1);
    cyc(0, 0, 0, "release");
    ticks(INV - 1, 1'b0, "shield_hold");
    chk("shield.before_end", 32'(invuln), 1);
    cyc(0, 1, 1, "shield_last_tick_hit");
    chk("shield.ended", 32'(invuln), 0);
    chk("shield.no_hit_on_exit", 32'(lives), 2);
    cyc(0, 0, 0, "release2");

    // Collision held for 100 frames costs a single life.
    cyc(0, 1, 0, "hold_hit");
    ticks(100, 1'b1, "hold_frames");
    chk("hold.lives", 32'(lives), 1);
    chk("hold.back_to_play", 32'(invuln), 0);
    cyc(0, 0, 0, "hold_release");

    cyc(0, 1, 0, "fatal_hit");
    chk("over.gameover", 32'(gameover), 1);
    chk("over.playing", 32'(playing), 0);
    chk("over.lives", 32'(lives), 0);
    cyc(0, 0, 0, "over_release");

    ticks(50, 1'b0, "over_hold");
    cyc(1, 0, 0, "over_early_start");
    chk("over.early_start", 32'(gameover), 1);
    ticks(HOLD - 51, 1'b0, "over_hold2");
    cyc(1, 0, 1, "over_start_tick_cnt1");
    chk("over.start_tick", 32'(gameover), 1);
    cyc(1, 0, 0, "over_restart");
    chk("restart.gameover", 32'(gameover), 0);
    chk("restart.lives", 32'(lives), 3);
    chk("restart.playing", 32'(playing), 1);

    // Asynchronous reset in the middle of a shield.
    cyc(0, 1, 0, "pre_reset_hit");
    ticks(5, 1'b0, "pre_reset_ticks");
    async_reset("mid_invuln_reset");
    cyc(0, 0, 0, "post_reset");
    cyc(1, 0, 0, "post_reset_start");
    chk("post_reset.lives", 32'(lives), 3);

`ifdef GAMEOVER_EXTRA_LIFE_EN
    cyc(0, 1, 0, "el_h1");
    ticks(INV, 1'b0, "el_w1");
    cyc(0, 1, 0, "el_h2");
    ticks(INV, 1'b0, "el_w2");
    chk("el.one_life", 32'(lives), 1);
    el = 1'b1;
    cyc(0, 0, 0, "el_prime");
    chk("el.gain", 32'(lives), 2);
    ticks(0, 1'b0, "none");
    cyc(0, 1, 0, "el_h3");
    ticks(INV, 1'b0, "el_w3");
    chk("el.back_to_one", 32'(lives), 1);
    el = 1'b1;
    cyc(0, 1, 0, "el_and_hit");
    chk("el_hit.lives", 32'(lives), 1);
    chk("el_hit.invuln", 32'(invuln), 1);
    chk("el_hit.gameover", 32'(gameover), 0);
    for (int i = 0; i < 8; i++) begin
      el = 1'b1;
      cyc(0, 0, 0, "el_pulse");
    end
    chk("el.saturate", 32'(lives), LMAX);
`endif

    // Random play against the model.
    async_reset("rand_reset");
    for (int i = 0; i < 3000; i++) begin
      bit s, t;
      s = ($urandom_range(0, 29) == 0);
      t = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) collision = ~collision;
`ifdef GAMEOVER_EXTRA_LIFE_EN
      el = ($urandom_range(0, 63) == 0);
`endif
      cyc(s, collision, t, "rand");
      if (i == 1500) async_reset("rand_mid_reset");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
